// File: rtl/radix_iterative_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : radix_iterative_multiplier
//  Purpose  : Multi-cycle shift-and-add multiplier that retires RADIX_BITS
//             multiplier bits per clock. Signed (two's-complement) or unsigned
//             operation is selected per request. Single outstanding operation,
//             registered start/ready/done handshake.
//
//  Parameters
//    WIDTH        operand width in bits (multiple of RADIX_BITS)
//    RADIX_BITS   multiplier bits consumed per RUN cycle (1, 2 or 4)
//
//  Ports
//    clk           in   rising-edge clock
//    rst           in   synchronous active-high reset
//    start         in   operation request, sampled only while ready=1
//    is_signed     in   1: operands are two's-complement, 0: unsigned
//    multiplier    in   operand A [WIDTH]
//    multiplicand  in   operand B [WIDTH]
//    product       out  result [2*WIDTH], valid from done to next accept
//    ready         out  idle, able to accept start
//    done          out  one-cycle pulse, product valid
//
//  Build option
//    EARLY_TERM_EN  when defined, RUN exits as soon as the remaining
//                   multiplier bits are all zero (variable latency, same
//                   results). When undefined the latency is fixed at N+1.
//
//  Revision : 1.0  initial release
// ============================================================================
module radix_iterative_multiplier #(
    parameter int WIDTH      = 64,
    parameter int RADIX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 done
);

    // Number of RUN cycles needed to consume every multiplier digit.
    localparam int c_N  = WIDTH / RADIX_BITS;
    localparam int c_CW = $clog2(c_N + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    logic [WIDTH-1:0]     r_mcopy;      // remaining multiplier magnitude
    logic [2*WIDTH-1:0]   r_acc_b;      // multiplicand magnitude, pre-shifted
    logic [2*WIDTH-1:0]   r_acc;        // unsigned magnitude accumulator
    logic [c_CW-1:0]      r_cnt;        // RUN cycles still to go
    logic                 r_neg;        // result must be negated in FIX
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_done;

    // ------------------------------------------------------------------------
    // Operand conditioning at accept time
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg_in;

    // Negating the most-negative value wraps back to 2^(WIDTH-1), which is
    // exactly the wanted magnitude when the result is read as unsigned.
    assign w_mag_a  = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign w_mag_b  = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign w_neg_in = is_signed & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);

    // ------------------------------------------------------------------------
    // Per-cycle step: partial product of the low digit and the shifted operand
    // ------------------------------------------------------------------------
    logic [RADIX_BITS-1:0] w_digit;
    logic [2*WIDTH-1:0]    w_partial;
    logic [WIDTH-1:0]      w_mcopy_shift;
    logic [2*WIDTH-1:0]    w_acc_b_shift;
    logic [c_CW-1:0]       w_cnt_dec;
    logic                  w_last;

    assign w_digit       = r_mcopy[RADIX_BITS-1:0];
    assign w_mcopy_shift = r_mcopy >> RADIX_BITS;
    assign w_acc_b_shift = r_acc_b << RADIX_BITS;
    assign w_cnt_dec     = r_cnt - c_CW'(1);

    // acc_b * digit built as a small shift-and-add over the digit bits so no
    // general multiplier is inferred.
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (w_digit[i]) begin
                w_partial = w_partial + (r_acc_b << i);
            end
        end
    end

`ifdef EARLY_TERM_EN
    // Leave RUN once no set multiplier bits remain; the accumulator cannot
    // change any further, so the result is the same as running to cnt=0.
    assign w_last = (w_cnt_dec == '0) || (w_mcopy_shift == '0);
`else
    assign w_last = (w_cnt_dec == '0);
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_last) begin
                    w_state_next = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcopy   <= '0;
            r_acc_b   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // product is intentionally left holding the last result.
                    if (start) begin
                        r_mcopy <= w_mag_a;
                        r_acc_b <= {{WIDTH{1'b0}}, w_mag_b};
                        r_neg   <= w_neg_in;
                        r_acc   <= '0;
                        r_cnt   <= c_CW'(c_N);
                    end
                end
                c_ST_RUN: begin
                    r_acc   <= r_acc + w_partial;
                    r_mcopy <= w_mcopy_shift;
                    r_acc_b <= w_acc_b_shift;
                    r_cnt   <= w_cnt_dec;
                end
                c_ST_FIX: begin
                    r_product <= r_neg ? -r_acc : r_acc;
                    r_done    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready   = (r_state == c_ST_IDLE);
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: doc/radix_iterative_multiplier.md
# radix_iterative_multiplier

Parametrised multi-cycle shift-and-add multiplier that retires RADIX_BITS multiplier bits per clock. It supports signed (two's-complement) and unsigned operands per operation, and uses a registered start/ready/done handshake. It is the next-generation sequential multiplier for datapaths that trade latency for area. It sits between an issuing controller and a result consumer, and accepts one operation at a time.

## Interface
- WIDTH, 64, operand width in bits; must be a multiple of RADIX_BITS
- RADIX_BITS, 2, multiplier bits consumed per RUN cycle; legal values 1, 2, 4
- clk  input  1  rising-edge clock; sole clock
- rst  input  1  synchronous, active-high reset
- start  input  1  operation request; sampled only when ready=1
- is_signed  input  1  1: operands are two's-complement; 0: unsigned; sampled with start
- multiplier  input  WIDTH  operand A; sampled with start
- multiplicand  input  WIDTH  operand B; sampled with start
- product  output  2*WIDTH  result; valid from done until the next accepted start
- ready  output  1  block idle and able to accept start
- done  output  1  single-cycle pulse: product is valid

## Operation
- N = WIDTH/RADIX_BITS.
- State IDLE:
  - ready=1.
  - On start=1 at an edge:
    - Latch |multiplier| into mcopy and |multiplicand| into acc_b. acc_b is 2*WIDTH wide and zero-extended.
    - Absolute values apply only when is_signed=1. Otherwise the operands are latched raw.
    - Latch neg = is_signed & (msb(multiplier) ^ msb(multiplicand)).
    - Clear the accumulator, set cnt=N, and go to RUN.
- State RUN, each edge:
  - Take digit d = mcopy[RADIX_BITS-1:0]. Accumulator += acc_b * d, modulo 2^(2*WIDTH).
  - mcopy >>= RADIX_BITS; acc_b <<= RADIX_BITS; cnt -= 1.
  - Go to FIX when cnt reaches 0 (see Configuration for early exit).
- State FIX, one edge:
  - product <= neg ? -acc : acc (two's complement, 2*WIDTH).
  - done <= 1 and go to IDLE.
- Most-negative operand (-2^(WIDTH-1)): its magnitude is 2^(WIDTH-1), which is held exactly in WIDTH unsigned bits. -2^(WIDTH-1) squared = 2^(2*WIDTH-2) is exact.
- start while ready=0 is ignored; there is no queueing and no error flag.
- product is not cleared at start. It holds the previous result until the FIX edge of the new operation.
- Reset:
  - rst=1 at any edge, including mid-RUN or FIX, forces IDLE and aborts the operation.
  - Outputs after reset: product=0, done=0, ready=1. Internal cnt, mcopy, acc_b, acc and neg are cleared to 0.
  - rst has priority over start.

## Timing
- start accepted at edge E0: ready=0 from E0.
- RUN occupies edges E1..EN; FIX is at edge EN+1.
- done=1 and product valid in the cycle after EN+1. ready=1 in that same cycle.
- Fixed latency: N+1 edges from accept to done (early exit disabled).
- Back-to-back: start may be asserted in the done cycle. It is accepted, giving a throughput of 1 result per N+2 cycles.
- done is exactly one cycle wide; it never asserts without a preceding accepted start.

## Configuration
- Macro EARLY_TERM_EN.
- Defined:
  - At a RUN edge, go to FIX if cnt reaches 0 or the post-shift mcopy == 0.
  - RUN cycles = max(1, ceil((msb_index(|multiplier|)+1)/RADIX_BITS)).
  - Latency varies from 2 to N+1 edges. Results are identical to the undefined case.
- Undefined: latency is always N+1 edges. No zero-detect logic is built.

## Test plan
- WIDTH=8, RADIX_BITS=2, unsigned, 255 x 255 -> product=0xFE01; done exactly 5 edges after accept; ready low for those 5 edges.
- Signed, WIDTH=8:
  - -128 x -128 -> 0x4000.
  - -128 x 127 -> 0xC080.
  - 127 x -1 -> 0xFF81.
- Same operand bits 0x80 x 0x80 with is_signed=0 -> 0x4000; 0xFF x 0x01 unsigned -> 0x00FF, signed -> 0xFFFF.
- Handshake:
  - start held high during RUN is ignored and product is unchanged mid-run.
  - start in the done cycle is accepted.
  - Two consecutive results are correct, with done pulses spaced N+2=6 cycles apart.
- Reset: assert rst on the 3rd RUN edge -> next cycle product=0, done=0, ready=1. A subsequent 3 x 5 gives 15 with full latency.
- EARLY_TERM_EN defined, WIDTH=8, RADIX_BITS=2:
  - multiplier 3 -> done after 2 edges.
  - multiplier 0 -> product 0 after 2 edges.
  - multiplier 0x40 -> done after 5 edges.
  - Undefined: all three cases take 5 edges.
